// File: rtl/mandel_cmd_parser.sv
// Frames the 12-byte UART render command from RX8 and presents it to the
// iteration engine over a valid/ready handshake, with an inter-byte timeout.
module mandel_cmd_parser #(
  parameter int N_BIT       = 16,
  parameter int TIMEOUT_CYC = 70000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_ready,
  output logic             cfg_valid,
  input  logic             cfg_ready,
  output logic [8:0]       cfg_pix_x,
  output logic [7:0]       cfg_pix_y,
  output logic [N_BIT-1:0] cfg_cxs,
  output logic [N_BIT-1:0] cfg_cys,
  output logic [N_BIT-1:0] cfg_dcx,
  output logic [N_BIT-1:0] cfg_dcy,
  output logic [7:0]       cfg_maxit,
  output logic [3:0]       byte_cnt,
  output logic             err_tmo,
  output logic             err_ovr
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  // Expiry is taken on the cycle the counter would step to TIMEOUT_CYC-1.
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 2);
  localparam logic [3:0]    LAST_BYTE = 4'd11;

  // Handshake: cfg_* are stable whenever cfg_valid is high; a command is
  // transferred on any cycle with cfg_valid && cfg_ready, and cfg_valid
  // drops on the following edge unless a new command has completed.
  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic rx_s1_q, rx_s2_q, rx_prev_q;
  logic byte_edge;

  logic [3:0]       byte_cnt_q, byte_cnt_d;
  logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [10:0][7:0] sh_q, sh_d;

  logic             cfg_valid_q, cfg_valid_d;
  logic [8:0]       cfg_pix_x_q, cfg_pix_x_d;
  logic [7:0]       cfg_pix_y_q, cfg_pix_y_d;
  logic [N_BIT-1:0] cfg_cxs_q, cfg_cxs_d;
  logic [N_BIT-1:0] cfg_cys_q, cfg_cys_d;
  logic [N_BIT-1:0] cfg_dcx_q, cfg_dcx_d;
  logic [N_BIT-1:0] cfg_dcy_q, cfg_dcy_d;
  logic [7:0]       cfg_maxit_q, cfg_maxit_d;
  logic             err_tmo_q, err_tmo_d;
  logic             err_ovr_q, err_ovr_d;
  logic             accept;

  // rx_ready is asynchronous: two flops, then a rising-edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q   <= 1'b0;
      rx_s2_q   <= 1'b0;
      rx_prev_q <= 1'b0;
    end else begin
      rx_s1_q   <= rx_ready;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  assign byte_edge = rx_s2_q & ~rx_prev_q;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    tmo_cnt_d   = '0;
    sh_d        = sh_q;
    cfg_valid_d = cfg_valid_q;
    cfg_pix_x_d = cfg_pix_x_q;
    cfg_pix_y_d = cfg_pix_y_q;
    cfg_cxs_d   = cfg_cxs_q;
    cfg_cys_d   = cfg_cys_q;
    cfg_dcx_d   = cfg_dcx_q;
    cfg_dcy_d   = cfg_dcy_q;
    cfg_maxit_d = cfg_maxit_q;
    err_tmo_d   = 1'b0;
    err_ovr_d   = 1'b0;
    accept      = 1'b0;

    case (state_q)
      COLLECT: begin
        if (byte_edge) begin
          accept = 1'b1;
        end else if (byte_cnt_q != 4'd0) begin
          if (tmo_cnt_q == TMO_LAST) begin
            byte_cnt_d = 4'd0;
            err_tmo_d  = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (cfg_ready) begin
          state_d     = COLLECT;
          cfg_valid_d = 1'b0;
          accept      = byte_edge;
        end else if (byte_edge) begin
          err_ovr_d = 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase

    // Outputs are only touched on the final byte, so they never glitch mid-frame.
    if (accept) begin
      if (byte_cnt_q == LAST_BYTE) begin
        cfg_pix_x_d = {sh_q[0][0], sh_q[1]};
        cfg_pix_y_d = sh_q[2];
        cfg_cxs_d   = N_BIT'({sh_q[3], sh_q[4]});
        cfg_cys_d   = N_BIT'({sh_q[5], sh_q[6]});
        cfg_dcx_d   = N_BIT'({sh_q[7], sh_q[8]});
        cfg_dcy_d   = N_BIT'({sh_q[9], sh_q[10]});
        cfg_maxit_d = rx_data;
        cfg_valid_d = 1'b1;
        state_d     = HOLD;
        byte_cnt_d  = 4'd0;
      end else begin
        sh_d[byte_cnt_q] = rx_data;
        byte_cnt_d       = byte_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      byte_cnt_q  <= 4'd0;
      tmo_cnt_q   <= '0;
      sh_q        <= '0;
      cfg_valid_q <= 1'b0;
      cfg_pix_x_q <= 9'd510;
      cfg_pix_y_q <= 8'd255;
      cfg_cxs_q   <= '0;
      cfg_cys_q   <= '0;
      cfg_dcx_q   <= '0;
      cfg_dcy_q   <= '0;
      cfg_maxit_q <= 8'd100;
      err_tmo_q   <= 1'b0;
      err_ovr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      sh_q        <= sh_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_pix_x_q <= cfg_pix_x_d;
      cfg_pix_y_q <= cfg_pix_y_d;
      cfg_cxs_q   <= cfg_cxs_d;
      cfg_cys_q   <= cfg_cys_d;
      cfg_dcx_q   <= cfg_dcx_d;
      cfg_dcy_q   <= cfg_dcy_d;
      cfg_maxit_q <= cfg_maxit_d;
      err_tmo_q   <= err_tmo_d;
      err_ovr_q   <= err_ovr_d;
    end
  end

  assign cfg_valid = cfg_valid_q;
  assign cfg_pix_x = cfg_pix_x_q;
  assign cfg_pix_y = cfg_pix_y_q;
  assign cfg_cxs   = cfg_cxs_q;
  assign cfg_cys   = cfg_cys_q;
  assign cfg_dcx   = cfg_dcx_q;
  assign cfg_dcy   = cfg_dcy_q;
  assign cfg_maxit = cfg_maxit_q;
  assign byte_cnt  = byte_cnt_q;
  assign err_tmo   = err_tmo_q;
  assign err_ovr   = err_ovr_q;

endmodule

// File: tb/tb_mandel_cmd_parser.sv
// Bench for mandel_cmd_parser: frame-level reference model compared every
// cycle, plus directed boundary cases with hand-computed expectations.
module tb_mandel_cmd_parser;

  localparam int N_BIT = 16;
  localparam int T     = 250;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       rx_data;
  logic             rx_ready;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [8:0]       cfg_pix_x;
  logic [7:0]       cfg_pix_y;
  logic [N_BIT-1:0] cfg_cxs, cfg_cys, cfg_dcx, cfg_dcy;
  logic [7:0]       cfg_maxit;
  logic [3:0]       byte_cnt;
  logic             err_tmo, err_ovr;

  mandel_cmd_parser #(.N_BIT(N_BIT), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_ready(rx_ready),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pix_x(cfg_pix_x), .cfg_pix_y(cfg_pix_y),
    .cfg_cxs(cfg_cxs), .cfg_cys(cfg_cys), .cfg_dcx(cfg_dcx), .cfg_dcy(cfg_dcy),
    .cfg_maxit(cfg_maxit), .byte_cnt(byte_cnt),
    .err_tmo(err_tmo), .err_ovr(err_ovr)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int dut_tmo_n = 0;
  int dut_ovr_n = 0;
  bit cmp_en = 0;
  bit rand_on = 0;

  // ---------------- reference model ----------------
  logic       m_h1, m_h2, m_h3;
  logic [7:0] m_frame[$];
  bit         m_pend, m_tmo, m_ovr;
  int         m_idle;
  int         m_pix_x, m_pix_y, m_cxs, m_cys, m_dcx, m_dcy, m_maxit;

  function automatic void model_reset();
    m_h1 = 0; m_h2 = 0; m_h3 = 0;
    m_frame.delete();
    m_pend = 0; m_tmo = 0; m_ovr = 0; m_idle = 0;
    m_pix_x = 510; m_pix_y = 255;
    m_cxs = 0; m_cys = 0; m_dcx = 0; m_dcy = 0; m_maxit = 100;
  endfunction

  function automatic void model_decode();
    m_pix_x = (int'(m_frame[0]) % 2) * 256 + int'(m_frame[1]);
    m_pix_y = int'(m_frame[2]);
    m_cxs   = int'(m_frame[3]) * 256 + int'(m_frame[4]);
    m_cys   = int'(m_frame[5]) * 256 + int'(m_frame[6]);
    m_dcx   = int'(m_frame[7]) * 256 + int'(m_frame[8]);
    m_dcy   = int'(m_frame[9]) * 256 + int'(m_frame[10]);
    m_maxit = int'(m_frame[11]);
  endfunction

  // One clock edge: a byte arrives when rx_ready was seen low then high,
  // with two edges of synchronizer delay in between.
  function automatic void model_step();
    bit took;
    took  = m_h2 && !m_h3;
    m_tmo = 0;
    m_ovr = 0;
    if (m_pend) begin
      if (cfg_ready) begin
        m_pend = 0;
        if (took) begin
          m_frame.push_back(rx_data);
          m_idle = 0;
        end
      end else if (took) begin
        m_ovr = 1;
      end
    end else if (took) begin
      m_frame.push_back(rx_data);
      m_idle = 0;
      if (m_frame.size() == 12) begin
        model_decode();
        m_pend = 1;
        m_frame.delete();
      end
    end else if (m_frame.size() != 0) begin
      m_idle++;
      if (m_idle == T - 1) begin
        m_frame.delete();
        m_idle = 0;
        m_tmo  = 1;
      end
    end
    m_h3 = m_h2;
    m_h2 = m_h1;
    m_h1 = rx_ready;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("cfg_valid", 32'(cfg_valid), 32'(m_pend));
        chk("byte_cnt",  32'(byte_cnt),  32'(m_frame.size()));
        chk("cfg_pix_x", 32'(cfg_pix_x), 32'(m_pix_x));
        chk("cfg_pix_y", 32'(cfg_pix_y), 32'(m_pix_y));
        chk("cfg_cxs",   32'(cfg_cxs),   32'(m_cxs));
        chk("cfg_cys",   32'(cfg_cys),   32'(m_cys));
        chk("cfg_dcx",   32'(cfg_dcx),   32'(m_dcx));
        chk("cfg_dcy",   32'(cfg_dcy),   32'(m_dcy));
        chk("cfg_maxit", 32'(cfg_maxit), 32'(m_maxit));
        chk("err_tmo",   32'(err_tmo),   32'(m_tmo));
        chk("err_ovr",   32'(err_ovr),   32'(m_ovr));
        if (err_tmo === 1'b1) dut_tmo_n++;
        if (err_ovr === 1'b1) dut_ovr_n++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [7:0] frame_a [12] = '{8'h01, 8'hFD, 8'hFF, 8'hE0, 8'h00, 8'hF0,
                               8'h00, 8'h00, 8'h20, 8'h00, 8'h20, 8'h64};
  logic [7:0] frame_b [12] = '{8'h00, 8'h7F, 8'h3C, 8'h12, 8'h34, 8'h56,
                               8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h0A};

  task automatic send_byte(input logic [7:0] b, input int h, input int l);
    rx_data  = b;
    rx_ready = 1'b1;
    repeat (h) @(negedge clk);
    rx_ready = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic send_frame(input int which, input int h);
    for (int i = 0; i < 12; i++)
      send_byte((which == 0) ? frame_a[i] : frame_b[i], h, 3);
  endtask

  task automatic pulse_ready();
    cfg_ready = 1'b1;
    @(negedge clk);
    cfg_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_frame_a(input string tag);
    chk({tag, "_pix_x"}, 32'(cfg_pix_x), 32'd509);
    chk({tag, "_pix_y"}, 32'(cfg_pix_y), 32'd255);
    chk({tag, "_cxs"},   32'(cfg_cxs),   32'hE000);
    chk({tag, "_cys"},   32'(cfg_cys),   32'hF000);
    chk({tag, "_dcx"},   32'(cfg_dcx),   32'h0020);
    chk({tag, "_dcy"},   32'(cfg_dcy),   32'h0020);
    chk({tag, "_maxit"}, 32'(cfg_maxit), 32'd100);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int tmo0, ovr0, h, l, r;
    rst_n = 1'b0; rx_data = 8'h00; rx_ready = 1'b0; cfg_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(cfg_valid), 32'd0);
    chk("rst_pix_x", 32'(cfg_pix_x), 32'd510);
    chk("rst_maxit", 32'(cfg_maxit), 32'd100);
    rst_n = 1'b1;
    cmp_en = 1;
    @(negedge clk);

    // Basic frame, engine not ready.
    send_frame(0, 2);
    chk("f1_valid", 32'(cfg_valid), 32'd1);
    chk_frame_a("f1");

    // Byte during HOLD is dropped; then a one-cycle transfer.
    ovr0 = dut_ovr_n;
    send_byte(8'h55, 2, 3);
    chk("hold_cnt", 32'(byte_cnt), 32'd0);
    chk("hold_ovr", 32'(dut_ovr_n - ovr0), 32'd1);
    cfg_ready = 1'b1;
    @(negedge clk);
    cfg_ready = 1'b0;
    chk("xfer_valid", 32'(cfg_valid), 32'd0);
    chk("xfer_keep", 32'(cfg_pix_x), 32'd509);
    @(negedge clk);

    // Partial frame then exact timeout cycle.
    tmo0 = dut_tmo_n;
    for (int i = 0; i < 5; i++) send_byte(8'(i + 1), 2, 2);
    repeat (T - 3) @(negedge clk);
    chk("tmo_pre_flag", 32'(err_tmo), 32'd0);
    chk("tmo_pre_cnt", 32'(byte_cnt), 32'd5);
    @(negedge clk);
    chk("tmo_flag", 32'(err_tmo), 32'd1);
    chk("tmo_cnt", 32'(byte_cnt), 32'd0);
    repeat (3) @(negedge clk);
    chk("tmo_count", 32'(dut_tmo_n - tmo0), 32'd1);
    send_frame(0, 2);
    chk("f2_valid", 32'(cfg_valid), 32'd1);
    chk_frame_a("f2");

    // Byte edge coincident with the transfer cycle.
    ovr0 = dut_ovr_n;
    rx_data = 8'hA5; rx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cfg_ready = 1'b1;
    @(negedge clk);
    cfg_ready = 1'b0; rx_ready = 1'b0;
    chk("coin_cnt", 32'(byte_cnt), 32'd1);
    chk("coin_valid", 32'(cfg_valid), 32'd0);
    repeat (2) @(negedge clk);
    chk("coin_ovr", 32'(dut_ovr_n - ovr0), 32'd0);
    repeat (T + 2) @(negedge clk);

    // Byte edge coincident with timeout expiry.
    tmo0 = dut_tmo_n;
    send_byte(8'h11, 2, 2);
    repeat (T - 5) @(negedge clk);
    send_byte(8'h22, 2, 1);
    chk("tmo_coin_cnt", 32'(byte_cnt), 32'd2);
    chk("tmo_coin_flag", 32'(err_tmo), 32'd0);
    repeat (2) @(negedge clk);
    chk("tmo_coin_n", 32'(dut_tmo_n - tmo0), 32'd0);
    repeat (T + 2) @(negedge clk);

    // Asynchronous reset mid-frame.
    for (int i = 0; i < 8; i++) send_byte(8'(i + 8'h40), 2, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(cfg_valid), 32'd0);
    chk("arst_cnt",   32'(byte_cnt),  32'd0);
    chk("arst_pix_x", 32'(cfg_pix_x), 32'd510);
    chk("arst_pix_y", 32'(cfg_pix_y), 32'd255);
    chk("arst_cxs",   32'(cfg_cxs),   32'd0);
    chk("arst_maxit", 32'(cfg_maxit), 32'd100);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(1, 2);
    chk("f3_valid", 32'(cfg_valid), 32'd1);
    chk("f3_pix_x", 32'(cfg_pix_x), 32'd127);
    chk("f3_pix_y", 32'(cfg_pix_y), 32'd60);
    chk("f3_cxs",   32'(cfg_cxs),   32'h1234);
    chk("f3_dcy",   32'(cfg_dcy),   32'hDEF0);
    chk("f3_maxit", 32'(cfg_maxit), 32'd10);
    pulse_ready();

    // Long rx_ready high time: one byte per rising edge.
    send_frame(0, 100);
    chk("f4_valid", 32'(cfg_valid), 32'd1);
    chk_frame_a("f4");
    pulse_ready();

    // Randomized byte stream with random engine readiness.
    rand_on = 1;
    fork
      begin
        while (rand_on) begin
          @(negedge clk);
          cfg_ready = ($urandom_range(0, 3) == 0);
        end
        cfg_ready = 1'b0;
      end
      begin
        for (int n = 0; n < 400; n++) begin
          h = $urandom_range(1, 4);
          r = $urandom_range(0, 39);
          if (r == 0) l = T + $urandom_range(0, 4);
          else if (r == 1) l = T - 2 - h + $urandom_range(0, 2);
          else l = $urandom_range(2, 5);
          send_byte(8'($urandom_range(0, 255)), h, l);
        end
        rand_on = 0;
      end
    join
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
